branch_controller: RTL and testbench

Sequencing controller for the ID-stage `BranchComparator`.
- Decides when the comparator result may be used: only once the forwarding unit reports both operands valid.
- Stalls the front end while a branch waits on operands.
- Issues a registered one-cycle PC redirect with an IF/ID flush for every taken branch or jump.
- Sits between the ID-stage comparator, the hazard/forwarding unit and the PC/IF-ID pipeline register controls.

---
 rtl/branch_controller_if.sv | 41 ++++
 rtl/branch_controller.sv | 167 ++++++++++++++++
 tb/tb_branch_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/branch_controller_if.sv
// Bundle between the ID-stage branch controller and the pipeline (comparator, forwarding, PC/IF-ID controls).
// Optional statistics signals appear when BRANCH_STATS_EN is defined.
interface branch_controller_if;
  logic        Valid_ID;
  logic [3:0]  BranchType;
  logic        OperandsReady;
  logic        Branch;
  logic [31:0] Target;
  logic        Stall;
  logic        Bubble;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        Flush_IF_ID;
  logic        Resolved;
  logic        HazardErr;
`ifdef BRANCH_STATS_EN
  logic [15:0] TakenCount;
  logic [15:0] NotTakenCount;
  logic [15:0] StallCycles;

  modport master (
    output Valid_ID, BranchType, OperandsReady, Branch, Target,
    input  Stall, Bubble, PCSrc, PCTarget, Flush_IF_ID, Resolved, HazardErr,
    input  TakenCount, NotTakenCount, StallCycles
  );
  modport slave (
    input  Valid_ID, BranchType, OperandsReady, Branch, Target,
    output Stall, Bubble, PCSrc, PCTarget, Flush_IF_ID, Resolved, HazardErr,
    output TakenCount, NotTakenCount, StallCycles
  );
`else
  modport master (
    output Valid_ID, BranchType, OperandsReady, Branch, Target,
    input  Stall, Bubble, PCSrc, PCTarget, Flush_IF_ID, Resolved, HazardErr
  );
  modport slave (
    input  Valid_ID, BranchType, OperandsReady, Branch, Target,
    output Stall, Bubble, PCSrc, PCTarget, Flush_IF_ID, Resolved, HazardErr
  );
`endif
endinterface

// File: rtl/branch_controller.sv
// ID-stage branch sequencing: waits for forwarded operands, stalls, and issues a one-cycle PC redirect/flush.
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken/stall-cycle counters.
module branch_controller #(
  parameter int unsigned MAX_WAIT = 4
) (
  input logic             Clk,
  input logic             Reset_n,
  branch_controller_if.slave bus
);

  localparam int unsigned TGT_W  = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [3:0] BT_FIRST = 4'b0011;
  localparam logic [3:0] BT_JUMP  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_OPS = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               hazard_q, hazard_d;
  logic               pcsrc_q, pcsrc_d;
  logic               flush_q, flush_d;
  logic               resolved_q, resolved_d;
  logic [TGT_W-1:0]   target_q, target_d;

  logic               is_ct_c;
  logic               is_jump_c;
  logic               stall_c;
  logic               taken_c;
  logic               not_taken_c;

  // Control-transfer decode: codes 0011..1001 with a valid ID instruction.
  assign is_jump_c = (bus.BranchType == BT_JUMP);
  assign is_ct_c   = bus.Valid_ID && (bus.BranchType >= BT_FIRST) && (bus.BranchType <= BT_JUMP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      hazard_q   <= 1'b0;
      pcsrc_q    <= 1'b0;
      flush_q    <= 1'b0;
      resolved_q <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hazard_q   <= hazard_d;
      pcsrc_q    <= pcsrc_d;
      flush_q    <= flush_d;
      resolved_q <= resolved_d;
      target_q   <= target_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hazard_d    = hazard_q;
    pcsrc_d     = 1'b0;
    flush_d     = 1'b0;
    resolved_d  = 1'b0;
    target_d    = '0;
    stall_c     = 1'b0;
    taken_c     = 1'b0;
    not_taken_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_ct_c) begin
          if (is_jump_c) begin
            taken_c = 1'b1;
          end else if (bus.OperandsReady) begin
            taken_c     = bus.Branch;
            not_taken_c = !bus.Branch;
          end else begin
            stall_c    = 1'b1;
            wait_cnt_d = CNT_W'(1);
            state_d    = S_WAIT_OPS;
          end
        end
      end
      S_WAIT_OPS: begin
        // BranchType/Target are held by the IF/ID stall, so only readiness matters here.
        if (bus.OperandsReady) begin
          taken_c     = is_jump_c || bus.Branch;
          not_taken_c = !(is_jump_c || bus.Branch);
          wait_cnt_d  = '0;
          state_d     = S_IDLE;
        end else begin
          stall_c = 1'b1;
          if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      S_REDIRECT: begin
        // The ID instruction here is the wrong-path fetch being flushed.
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase

    if (taken_c) begin
      state_d    = S_REDIRECT;
      pcsrc_d    = 1'b1;
      flush_d    = 1'b1;
      resolved_d = 1'b1;
      target_d   = bus.Target;
    end else if (not_taken_c) begin
      state_d    = S_IDLE;
      resolved_d = 1'b1;
    end

    if (stall_c && (32'(wait_cnt_d) >= 32'(MAX_WAIT))) begin
      hazard_d = 1'b1;
    end
  end

  // Stall is combinational; forced low while reset is asserted so every output reads 0.
  assign bus.Stall       = stall_c && Reset_n;
  assign bus.Bubble      = stall_c && Reset_n;
  assign bus.PCSrc       = pcsrc_q;
  assign bus.PCTarget    = target_q;
  assign bus.Flush_IF_ID = flush_q;
  assign bus.Resolved    = resolved_q;
  assign bus.HazardErr   = hazard_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q;
  logic [STAT_W-1:0] nt_cnt_q;
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (taken_c && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + STAT_W'(1);
      end
      if (not_taken_c && (nt_cnt_q != '1)) begin
        nt_cnt_q <= nt_cnt_q + STAT_W'(1);
      end
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
    end
  end

  assign bus.TakenCount    = taken_cnt_q;
  assign bus.NotTakenCount = nt_cnt_q;
  assign bus.StallCycles   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_controller.sv
// Directed bench for branch_controller: redirect timing, not-taken resolve, operand stalls, hazard flag, reset abort.
module tb_branch_controller;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  branch_controller_if bif ();

  branch_controller #(.MAX_WAIT(4)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] t, input logic r, input logic b, input logic [31:0] tg);
    bif.Valid_ID      = v;
    bif.BranchType    = t;
    bif.OperandsReady = r;
    bif.Branch        = b;
    bif.Target        = tg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic pcsrc, input logic [31:0] tgt,
                          input logic flush, input logic res);
    chk({tag, ".PCSrc"},       32'(bif.PCSrc),       32'(pcsrc));
    chk({tag, ".PCTarget"},    bif.PCTarget,         tgt);
    chk({tag, ".Flush_IF_ID"}, 32'(bif.Flush_IF_ID), 32'(flush));
    chk({tag, ".Resolved"},    32'(bif.Resolved),    32'(res));
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, ".Stall"},  32'(bif.Stall),  32'(exp));
    chk({tag, ".Bubble"}, 32'(bif.Bubble), 32'(exp));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0);

    // Reset state
    #2;
    chk_regs("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk_stall("reset", 1'b0);
    chk("reset.HazardErr", 32'(bif.HazardErr), 32'h0);
`ifdef BRANCH_STATS_EN
    chk("reset.TakenCount",    32'(bif.TakenCount),    32'h0);
    chk("reset.NotTakenCount", 32'(bif.NotTakenCount), 32'h0);
    chk("reset.StallCycles",   32'(bif.StallCycles),   32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // beq taken, operands ready
    drive(1'b1, 4'b0100, 1'b1, 1'b1, 32'h0000_0040);
    #1 chk_stall("beq", 1'b0);
    tick();
    chk_regs("beq.redirect", 1'b1, 32'h40, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_regs("beq.after", 1'b0, 32'h0, 1'b0, 1'b0);

    // bne not taken, then bgtz back-to-back in the next IDLE cycle
    drive(1'b1, 4'b0101, 1'b1, 1'b0, 32'h0000_0080);
    #1 chk_stall("bne", 1'b0);
    tick();
    chk_regs("bne.resolve", 1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 4'b0110, 1'b0, 1'b0, 32'h0000_0100);
    #1 chk_stall("bgtz.w1", 1'b1);
    tick();
    chk_regs("bgtz.w1.regs", 1'b0, 32'h0, 1'b0, 1'b0);
    #1 chk_stall("bgtz.w2", 1'b1);
    tick();
    drive(1'b1, 4'b0110, 1'b1, 1'b1, 32'h0000_0100);
    #1 chk_stall("bgtz.ready", 1'b0);
    chk("bgtz.ready.PCSrc", 32'(bif.PCSrc), 32'h0);
    tick();
    chk_regs("bgtz.redirect", 1'b1, 32'h100, 1'b1, 1'b1);
    chk("bgtz.HazardErr", 32'(bif.HazardErr), 32'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
    tick();

    // bltz with a 5-cycle operand wait: HazardErr follows the 4th wait cycle
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 32'h0000_0200);
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk_stall($sformatf("bltz.w%0d", i), 1'b1);
      chk($sformatf("bltz.w%0d.HazardErr", i), 32'(bif.HazardErr), (i >= 5) ? 32'h1 : 32'h0);
      tick();
    end
    drive(1'b1, 4'b1000, 1'b1, 1'b0, 32'h0000_0200);
    #1 chk_stall("bltz.ready", 1'b0);
    tick();
    chk_regs("bltz.resolve", 1'b0, 32'h0, 1'b0, 1'b1);
    chk("bltz.HazardErr.sticky", 32'(bif.HazardErr), 32'h1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("bltz.HazardErr.idle", 32'(bif.HazardErr), 32'h1);

    // Jump ignores OperandsReady; beq during REDIRECT is discarded; non-CT code is ignored
    drive(1'b1, 4'b1001, 1'b0, 1'b0, 32'h0000_0300);
    #1 chk_stall("jump", 1'b0);
    tick();
    chk_regs("jump.redirect", 1'b1, 32'h300, 1'b1, 1'b1);
    drive(1'b1, 4'b0100, 1'b1, 1'b1, 32'h0000_0400);
    #1 chk_stall("beq.in.redirect", 1'b0);
    tick();
    chk_regs("beq.in.redirect.regs", 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 4'b1010, 1'b0, 1'b1, 32'h0000_0500);
    #1 chk_stall("nonct", 1'b0);
    tick();
    chk_regs("nonct.regs", 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset during WAIT_OPS aborts with everything cleared
    drive(1'b1, 4'b0100, 1'b0, 1'b1, 32'h0000_0600);
    tick();
    #1 chk_stall("beq.wait", 1'b1);
    rst_n = 1'b0;
    #1;
    chk_regs("midreset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk_stall("midreset", 1'b0);
    chk("midreset.HazardErr", 32'(bif.HazardErr), 32'h0);
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick();
    chk_regs("postreset", 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 4'b0100, 1'b1, 1'b1, 32'h0000_0700);
    #1 chk_stall("postreset.beq", 1'b0);
    tick();
    chk_regs("postreset.redirect", 1'b1, 32'h700, 1'b1, 1'b1);

`ifdef BRANCH_STATS_EN
    drive(1'b1, 4'b1001, 1'b1, 1'b0, 32'h0000_0800);
    tick();
    drive(1'b1, 4'b1001, 1'b1, 1'b0, 32'h0000_0800);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("stats.TakenCount",    32'(bif.TakenCount),    32'h2);
    chk("stats.NotTakenCount", 32'(bif.NotTakenCount), 32'h0);
    chk("stats.StallCycles",   32'(bif.StallCycles),   32'h0);
`else
    drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
    tick();
`endif
    chk_regs("final", 1'b0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
